// File: rtl/truth_sweep_driver.sv
// rtl/truth_sweep_driver.sv - drives all 16 {w,x,y,z} vectors into the breadboard and checks {f4,f5,f6} against golden.
// Optional first-failing-row capture is enabled by defining TRUTH_SWEEP_FIRST_FAIL_EN.
module truth_sweep_driver #(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    output logic [3:0] stim_o,
    input  logic [2:0] resp_i,
    output logic       busy_o,
    output logic       row_valid_o,
    output logic [3:0] row_idx_o,
    output logic [2:0] row_resp_o,
    output logic [2:0] row_exp_o,
    output logic       row_fail_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [4:0] err_cnt_o,
    output logic [3:0] first_fail_o,
    output logic       first_vld_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    logic [1:0]       state;
    logic [3:0]       row;
    logic [CNT_W-1:0] cnt;
    logic             w, x, y, z;
    logic [2:0]       golden;
    logic             row_mismatch;

    // stim_o equals row while driving, so the golden value is derived from row
    assign {w, x, y, z} = row;
    assign golden = {y & z,
                     (~y & ~z) | (~w & ~x),
                     (~w & ~x & z) | (~w & ~x & y) | (x & ~y & z) | (w & ~x & ~y & ~z)};
    assign row_mismatch = (resp_i != golden);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            row         <= 4'd0;
            cnt         <= '0;
            stim_o      <= 4'd0;
            busy_o      <= 1'b0;
            row_valid_o <= 1'b0;
            row_idx_o   <= 4'd0;
            row_resp_o  <= 3'd0;
            row_exp_o   <= 3'd0;
            row_fail_o  <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            err_cnt_o   <= 5'd0;
        end else begin
            row_valid_o <= 1'b0;
            done_o      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state     <= ST_DRIVE;
                        row       <= 4'd0;
                        cnt       <= '0;
                        stim_o    <= 4'd0;
                        err_cnt_o <= 5'd0;
                        pass_o    <= 1'b0;
                        busy_o    <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    row_valid_o <= 1'b1;
                    row_idx_o   <= row;
                    row_resp_o  <= resp_i;
                    row_exp_o   <= golden;
                    row_fail_o  <= row_mismatch;
                    // at most 16 increments into 5 bits, so no wrap is possible
                    err_cnt_o   <= err_cnt_o + 5'(row_mismatch);
                    if (row == 4'd15) begin
                        state <= ST_DONE;
                    end else begin
                        row    <= row + 4'd1;
                        stim_o <= row + 4'd1;
                        cnt    <= '0;
                        state  <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    done_o <= 1'b1;
                    pass_o <= (err_cnt_o == 5'd0);
                    busy_o <= 1'b0;
                    row    <= 4'd0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TRUTH_SWEEP_FIRST_FAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_o <= 4'd0;
            first_vld_o  <= 1'b0;
        end else if (state == ST_IDLE && start_i) begin
            first_fail_o <= 4'd0;
            first_vld_o  <= 1'b0;
        end else if (state == ST_SAMPLE && row_mismatch && !first_vld_o) begin
            first_fail_o <= row;
            first_vld_o  <= 1'b1;
        end
    end
`else
    assign first_fail_o = 4'd0;
    assign first_vld_o  = 1'b0;
`endif

endmodule

// File: tb/tb_truth_sweep_driver.sv
// tb/tb_truth_sweep_driver.sv - scoreboard bench for truth_sweep_driver with a faultable breadboard model.
module tb_truth_sweep_driver;

    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start1 = 1'b0;

    always #5 clk = ~clk;

    logic [3:0] stim, row_idx, first_fail;
    logic [2:0] resp, row_resp, row_exp;
    logic       busy, row_valid, row_fail, done, pass, first_vld;
    logic [4:0] err_cnt;

    logic [3:0] stim1, row_idx1, first_fail1;
    logic [2:0] resp1, row_resp1, row_exp1;
    logic       busy1, row_valid1, row_fail1, done1, pass1, first_vld1;
    logic [4:0] err_cnt1;

    // {f4,f5,f6} per row 0..15
    logic [2:0] gold_tab [0:15] = '{3'd2, 3'd3, 3'd3, 3'd7, 3'd2, 3'd1, 3'd0, 3'd4,
                                    3'd3, 3'd0, 3'd0, 3'd4, 3'd2, 3'd1, 3'd0, 3'd4};
    int mode = 0;

    function automatic logic [2:0] bb(input int m, input logic [3:0] v);
        case (m)
            1:       return gold_tab[v] & 3'b011;
            2:       return ~gold_tab[v];
            default: return gold_tab[v];
        endcase
    endfunction

    assign resp  = bb(mode, stim);
    assign resp1 = gold_tab[stim1];

    truth_sweep_driver #(.SETTLE_CYC(S), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .stim_o(stim), .resp_i(resp),
        .busy_o(busy), .row_valid_o(row_valid), .row_idx_o(row_idx), .row_resp_o(row_resp),
        .row_exp_o(row_exp), .row_fail_o(row_fail), .done_o(done), .pass_o(pass),
        .err_cnt_o(err_cnt), .first_fail_o(first_fail), .first_vld_o(first_vld)
    );

    truth_sweep_driver #(.SETTLE_CYC(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .stim_o(stim1), .resp_i(resp1),
        .busy_o(busy1), .row_valid_o(row_valid1), .row_idx_o(row_idx1), .row_resp_o(row_resp1),
        .row_exp_o(row_exp1), .row_fail_o(row_fail1), .done_o(done1), .pass_o(pass1),
        .err_cnt_o(err_cnt1), .first_fail_o(first_fail1), .first_vld_o(first_vld1)
    );

    typedef struct {
        logic [3:0] idx;
        logic [2:0] resp;
        logic [2:0] exp;
        logic       fail;
        int         cyc;
    } row_t;

    row_t sb[$];
    row_t mon_e;

    int cyc = 0;
    int passed = 0;
    int total = 0;
    int s0 = 0, s1 = 0;
    int exp_err = 0, exp_ff = 0, exp_fv = 0;
    int done_cnt = 0, done_cyc = 0;
    int done1_cnt = 0;
    int done1_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && row_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                chk("row_idx",  32'(row_idx),  32'(mon_e.idx));
                chk("row_resp", 32'(row_resp), 32'(mon_e.resp));
                chk("row_exp",  32'(row_exp),  32'(mon_e.exp));
                chk("row_fail", 32'(row_fail), 32'(mon_e.fail));
                chk("row_cyc",  32'(cyc),      32'(mon_e.cyc));
            end
        end
        if (rst_n && done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (rst_n && done1) begin
            done1_cnt = done1_cnt + 1;
            done1_cyc.push_back(cyc);
            chk("s1_err_cnt", 32'(err_cnt1), 32'd0);
            chk("s1_pass", 32'(pass1), 32'd1);
        end
    end

    function automatic logic [31:0] outs0();
        return {3'b0, stim, busy, row_valid, row_idx, row_resp, row_exp, row_fail,
                done, pass, err_cnt, first_fail, first_vld};
    endfunction

    task automatic begin_sweep(input int m);
        logic [2:0] r_resp;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s0 = cyc;
        chk("busy_at_start", 32'(busy), 32'd1);
        chk("pass_cleared", 32'(pass), 32'd0);
        chk("err_cleared", 32'(err_cnt), 32'd0);
        chk("stim_row0", 32'(stim), 32'd0);
        exp_err = 0;
        exp_ff = 0;
        exp_fv = 0;
        for (int r = 0; r < 16; r++) begin
            row_t e;
            r_resp = bb(m, 4'(r));
            e.idx  = 4'(r);
            e.resp = r_resp;
            e.exp  = gold_tab[r];
            e.fail = (r_resp != gold_tab[r]);
            e.cyc  = s0 + (r + 1) * (S + 1);
            sb.push_back(e);
            if (e.fail) begin
                exp_err = exp_err + 1;
                if (exp_fv == 0) begin
                    exp_ff = r;
                    exp_fv = 1;
                end
            end
        end
    endtask

    task automatic finish_sweep();
        int  d0;
        bit  got;
        d0  = done_cnt;
        got = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("done_cyc", 32'(done_cyc), 32'(s0 + 16 * (S + 1) + 1));
        chk("err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("pass", 32'(pass), 32'(exp_err == 0));
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
`ifdef TRUTH_SWEEP_FIRST_FAIL_EN
        chk("first_fail", 32'(first_fail), 32'(exp_ff));
        chk("first_vld", 32'(first_vld), 32'(exp_fv));
`else
        chk("first_fail", 32'(first_fail), 32'd0);
        chk("first_vld", 32'(first_vld), 32'd0);
`endif
        @(negedge clk);
        #1;
        chk("done_pulse_width", 32'(done), 32'd0);
        chk("stim_holds_15", 32'(stim), 32'd15);
    endtask

    task automatic wait_stim(input logic [3:0] v);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #1;
            if (stim == v) begin
                got = 1'b1;
                break;
            end
        end
        chk("stim_reached", 32'(got), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d_before;
        bit got1;
        #12;
        chk("reset_outs", outs0(), 32'd0);
        chk("reset_stim1", 32'({busy1, done1, stim1, err_cnt1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // golden breadboard
        begin_sweep(0);
        finish_sweep();

        // f4 stuck-at-0
        begin_sweep(1);
        finish_sweep();

        // fully inverted responses
        begin_sweep(2);
        finish_sweep();

        // reset during DRIVE of row 5
        begin_sweep(0);
        wait_stim(4'd5);
        d_before = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midsweep_reset_outs", outs0(), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("no_done_after_reset", 32'(done_cnt), 32'(d_before));
        chk("idle_after_reset", 32'(busy), 32'd0);
        begin_sweep(0);
        finish_sweep();

        // start pulse mid-sweep is ignored
        begin_sweep(0);
        wait_stim(4'd7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_sweep();
        d_before = done_cnt;
        repeat (60) @(negedge clk);
        #1;
        chk("single_done", 32'(done_cnt), 32'(d_before));
        chk("no_restart", 32'(busy), 32'd0);

        // SETTLE_CYC=1 with start held: back-to-back sweeps
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        s1 = cyc;
        got1 = 1'b0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            #1;
            if (done1_cnt >= 3) begin
                got1 = 1'b1;
                break;
            end
        end
        start1 = 1'b0;
        chk("s1_three_dones", 32'(got1), 32'd1);
        if (done1_cyc.size() >= 3) begin
            chk("s1_first_done", 32'(done1_cyc[0]), 32'(s1 + 33));
            chk("s1_period_a", 32'(done1_cyc[1] - done1_cyc[0]), 32'd34);
            chk("s1_period_b", 32'(done1_cyc[2] - done1_cyc[1]), 32'd34);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
